// File: rtl/axi_ar_arbiter.sv
// -----------------------------------------------------------------------------
// axi_ar_arbiter
// Round-robin arbiter merging NUM_REQ AXI read-address (AR) channels into one,
// with a cap on the number of accepted-but-uncompleted read bursts.
//
// Once an AR is presented and not accepted, the arbiter locks onto that
// requester until the AR buffer accepts it. This keeps the master-side
// valid/payload stable, as AXI requires.
//
// Ports
//   clk_i           clock, all state on rising edge
//   rst_i           asynchronous active-high reset
//   slave_valid_i   per-requester AR valid
//   slave_data_i    per-requester packed AR payload, requester k at [k*AR_WIDTH +: AR_WIDTH]
//   slave_ready_o   per-requester AR ready (only the selected requester sees master_ready_i)
//   master_valid_o  arbitrated AR valid (combinational, zero latency)
//   master_data_o   arbitrated AR payload
//   master_src_o    index of the requester driving master_data_o
//   master_ready_i  AR ready from the AR buffer
//   r_done_i        one-cycle pulse per completed read burst
//   outstanding_o   registered count of outstanding bursts
// -----------------------------------------------------------------------------
module axi_ar_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int AR_WIDTH        = 71,
    parameter int MAX_OUTSTANDING = 8,
    localparam int SEL_W          = $clog2(NUM_REQ),
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            slave_valid_i,
    input  logic [NUM_REQ*AR_WIDTH-1:0]   slave_data_i,
    output logic [NUM_REQ-1:0]            slave_ready_o,
    output logic                          master_valid_o,
    output logic [AR_WIDTH-1:0]           master_data_o,
    output logic [SEL_W-1:0]              master_src_o,
    input  logic                          master_ready_i,
    input  logic                          r_done_i,
    output logic [CNT_W-1:0]              outstanding_o
);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [SEL_W-1:0]   rr_ptr_r;
    logic [SEL_W-1:0]   rr_ptr_next_s;
    logic [SEL_W-1:0]   lock_sel_r;
    logic [SEL_W-1:0]   lock_sel_next_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;

    logic               found_s;
    logic [SEL_W-1:0]   arb_sel_s;
    logic               can_arb_s;
    logic               valid_s;
    logic [SEL_W-1:0]   sel_s;
    logic               hs_s;
    logic               dec_s;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int idx_v;
        found_s   = 1'b0;
        arb_sel_s = rr_ptr_r;
        idx_v     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = (int'(rr_ptr_r) + i) % NUM_REQ;
            if (!found_s && slave_valid_i[idx_v]) begin
                found_s   = 1'b1;
                arb_sel_s = SEL_W'(idx_v);
            end else begin
                found_s   = found_s;
            end
        end
    end

    assign can_arb_s = (count_r < CNT_W'(MAX_OUTSTANDING));

    // Next-state and output decode; reset gates the outputs so they drop
    // immediately rather than waiting for the next edge.
    always_comb begin
        valid_s         = 1'b0;
        sel_s           = rr_ptr_r;
        state_next_s    = state_r;
        lock_sel_next_s = lock_sel_r;
        rr_ptr_next_s   = rr_ptr_r;

        if (rst_i) begin
            valid_s = 1'b0;
            sel_s   = rr_ptr_r;
        end else begin
            case (state_r)
                ST_ARB: begin
                    if (can_arb_s && found_s) begin
                        valid_s = 1'b1;
                        sel_s   = arb_sel_s;
                    end else begin
                        valid_s = 1'b0;
                        sel_s   = rr_ptr_r;
                    end
                end
                ST_LOCKED: begin
                    valid_s = 1'b1;
                    sel_s   = lock_sel_r;
                end
                default: begin
                    valid_s = 1'b0;
                    sel_s   = rr_ptr_r;
                end
            endcase

            if (valid_s && master_ready_i) begin
                state_next_s = ST_ARB;
                if (int'(sel_s) == NUM_REQ - 1) begin
                    rr_ptr_next_s = '0;
                end else begin
                    rr_ptr_next_s = sel_s + SEL_W'(1);
                end
            end else if (valid_s) begin
                state_next_s    = ST_LOCKED;
                lock_sel_next_s = sel_s;
            end else begin
                state_next_s = ST_ARB;
            end
        end
    end

    assign hs_s  = valid_s & master_ready_i;
    // A completion with nothing outstanding is ignored so the count cannot wrap.
    assign dec_s = r_done_i & (count_r != '0);

    // Outstanding-count update; a grant and a completion in one cycle cancel.
    always_comb begin
        count_next_s = count_r;
        case ({hs_s, dec_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // State, pointer, locked selection and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_ARB;
            rr_ptr_r   <= '0;
            lock_sel_r <= '0;
            count_r    <= '0;
        end else begin
            state_r    <= state_next_s;
            rr_ptr_r   <= rr_ptr_next_s;
            lock_sel_r <= lock_sel_next_s;
            count_r    <= count_next_s;
        end
    end

    // Per-requester ready: only the selected requester sees the buffer's ready.
    always_comb begin
        slave_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (valid_s && master_ready_i && (int'(sel_s) == k)) begin
                slave_ready_o[k] = 1'b1;
            end else begin
                slave_ready_o[k] = 1'b0;
            end
        end
    end

    assign master_valid_o = valid_s;
    assign master_src_o   = sel_s;
    assign master_data_o  = slave_data_i[int'(sel_s)*AR_WIDTH +: AR_WIDTH];
    assign outstanding_o  = count_r;

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_ar_arbiter
// Directed bench for axi_ar_arbiter. One instance uses default parameters;
// a second instance with MAX_OUTSTANDING = 2 exercises the throttle.
// -----------------------------------------------------------------------------
module tb_axi_ar_arbiter;

    localparam int NR = 4;
    localparam int AW = 71;

    logic            clk = 1'b0;
    logic            rst = 1'b1;

    logic [NR-1:0]    valid = '0;
    logic [NR*AW-1:0] data  = '0;
    logic [NR-1:0]    sready;
    logic             mvalid;
    logic [AW-1:0]    mdata;
    logic [1:0]       msrc;
    logic             mready = 1'b0;
    logic             done   = 1'b0;
    logic [3:0]       outst;

    logic [NR-1:0]    valid2  = '0;
    logic [NR-1:0]    sready2;
    logic             mvalid2;
    logic [AW-1:0]    mdata2;
    logic [1:0]       msrc2;
    logic             mready2 = 1'b0;
    logic             done2   = 1'b0;
    logic [1:0]       outst2;

    logic [AW-1:0]    pay [NR];

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    axi_ar_arbiter #(.NUM_REQ(NR), .AR_WIDTH(AW), .MAX_OUTSTANDING(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(valid), .slave_data_i(data), .slave_ready_o(sready),
        .master_valid_o(mvalid), .master_data_o(mdata), .master_src_o(msrc),
        .master_ready_i(mready), .r_done_i(done), .outstanding_o(outst)
    );

    axi_ar_arbiter #(.NUM_REQ(NR), .AR_WIDTH(AW), .MAX_OUTSTANDING(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(valid2), .slave_data_i(data), .slave_ready_o(sready2),
        .master_valid_o(mvalid2), .master_data_o(mdata2), .master_src_o(msrc2),
        .master_ready_i(mready2), .r_done_i(done2), .outstanding_o(outst2)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_cnt;
        for (int k = 0; k < NR; k++) begin
            pay[k] = AW'(64'hC0DE_0000_0000_0000) | AW'(k * 17 + 3);
            data[k*AW +: AW] = pay[k];
        end

        // Reset state, even with requesters asking
        valid = 4'hF;
        mready = 1'b1;
        #2;
        check("rst_mvalid", 128'(mvalid), 128'd0);
        check("rst_sready", 128'(sready), 128'd0);
        check("rst_src",    128'(msrc),   128'd0);
        check("rst_outst",  128'(outst),  128'd0);
        tick();
        rst = 1'b0;

        // All four valid, ready high: grants 0,1,2,3 in order
        for (int i = 0; i < NR; i++) begin
            #1;
            check($sformatf("rr_valid%0d", i), 128'(mvalid), 128'd1);
            check($sformatf("rr_src%0d", i),   128'(msrc),   128'(i));
            check($sformatf("rr_data%0d", i),  128'(mdata),  128'(pay[i]));
            check($sformatf("rr_sready%0d", i), 128'(sready), 128'(4'b0001 << i));
            tick();
        end
        valid = '0;
        mready = 1'b0;
        #1;
        check("rr_outst4", 128'(outst), 128'd4);

        // Lock on requester 2 while ready is low; requester 0 joins in cycle 2
        valid = 4'b0100;
        #1;
        check("lk_c1_src",    128'(msrc),   128'd2);
        check("lk_c1_sready", 128'(sready), 128'd0);
        tick();
        valid = 4'b0101;
        #1;
        check("lk_c2_src",  128'(msrc),  128'd2);
        check("lk_c2_data", 128'(mdata), 128'(pay[2]));
        tick();
        #1;
        check("lk_c3_src",   128'(msrc),   128'd2);
        check("lk_c3_valid", 128'(mvalid), 128'd1);
        tick();
        mready = 1'b1;
        #1;
        check("lk_c4_src",    128'(msrc),   128'd2);
        check("lk_c4_sready", 128'(sready), 128'd4);
        tick();
        valid = 4'b0001;
        #1;
        check("lk_next_src",    128'(msrc),   128'd0);
        check("lk_next_sready", 128'(sready), 128'd1);
        tick();
        valid = '0;
        mready = 1'b0;
        #1;
        check("lk_outst6", 128'(outst), 128'd6);

        // Drain to 1, then a grant coincident with a completion
        done = 1'b1;
        repeat (5) tick();
        done = 1'b0;
        #1;
        check("drain_outst1", 128'(outst), 128'd1);
        valid = 4'b0010;
        mready = 1'b1;
        done = 1'b1;
        #1;
        check("coinc_src", 128'(msrc), 128'd1);
        tick();
        valid = '0;
        mready = 1'b0;
        #1;
        check("coinc_outst1", 128'(outst), 128'd1);
        tick();
        #1;
        check("done_outst0", 128'(outst), 128'd0);
        tick();
        done = 1'b0;
        #1;
        check("underflow_outst0", 128'(outst), 128'd0);

        // Reset mid-cycle while locked on requester 2 (rr_ptr is now 2)
        valid = 4'b0100;
        #1;
        check("rl_src", 128'(msrc), 128'd2);
        tick();
        valid = 4'b0110;
        #2;
        rst = 1'b1;
        #1;
        check("rl_mvalid", 128'(mvalid), 128'd0);
        check("rl_sready", 128'(sready), 128'd0);
        check("rl_src0",   128'(msrc),   128'd0);
        tick();
        rst = 1'b0;
        valid = 4'b0101;
        mready = 1'b1;
        #1;
        check("post_rst_src",    128'(msrc),   128'd0);
        check("post_rst_sready", 128'(sready), 128'd1);
        tick();
        valid = '0;
        mready = 1'b0;
        #1;
        check("post_rst_outst", 128'(outst), 128'd1);

        // Throttle on the MAX_OUTSTANDING=2 instance
        valid2 = 4'hF;
        mready2 = 1'b1;
        hs_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (mvalid2 && mready2) hs_cnt++;
            tick();
        end
        check("thr_hs2",    128'(hs_cnt),  128'd2);
        check("thr_mvalid", 128'(mvalid2), 128'd0);
        check("thr_outst2", 128'(outst2),  128'd2);
        done2 = 1'b1;
        #1;
        check("thr_done_cycle_mvalid", 128'(mvalid2), 128'd0);
        tick();
        done2 = 1'b0;
        hs_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (mvalid2 && mready2) hs_cnt++;
            tick();
        end
        check("thr_hs_after_done", 128'(hs_cnt), 128'd1);
        check("thr_outst_end",     128'(outst2), 128'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/axi_ar_arbiter.md
AXI_AR_ARBITER -- requirements
Module: axi_ar_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of AR requesters (legal range 2..16).
REQ-002 SHALL have parameter AR_WIDTH, default 71, packed AR payload width {cache,prot,lock,burst,size,len,qos,region,addr,user,id}.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8, maximum accepted-but-uncompleted read bursts (legal range 1..255).
REQ-004 SHALL derive SEL_W = clog2(NUM_REQ) and CNT_W = clog2(MAX_OUTSTANDING+1).
REQ-005 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port slave_valid_i  input  NUM_REQ  per-requester AR valid.
REQ-008 SHALL have port slave_data_i  input  NUM_REQ*AR_WIDTH  per-requester payload; requester k occupies bits [k*AR_WIDTH +: AR_WIDTH].
REQ-009 SHALL have port slave_ready_o  output  NUM_REQ  per-requester AR ready.
REQ-010 SHALL have port master_valid_o  output  1  arbitrated AR valid toward the AR buffer.
REQ-011 SHALL have port master_data_o  output  AR_WIDTH  arbitrated payload.
REQ-012 SHALL have port master_src_o  output  SEL_W  index of requester currently driving master_data_o.
REQ-013 SHALL have port master_ready_i  input  1  AR ready from the AR buffer.
REQ-014 SHALL have port r_done_i  input  1  one-cycle pulse per completed read burst (R handshake with RLAST).
REQ-015 SHALL have port outstanding_o  output  CNT_W  current outstanding-burst count.

Function
REQ-016 SHALL implement a two-state FSM: ARB and LOCKED.
REQ-017 In ARB, when outstanding_o < MAX_OUTSTANDING and any slave_valid_i is set, SHALL select the first valid requester searching upward from rr_ptr with wrap-around, and assert master_valid_o combinationally in the same cycle (zero latency).
REQ-018 In ARB, with no valid requester or outstanding_o == MAX_OUTSTANDING, SHALL drive master_valid_o = 0 and all slave_ready_o = 0.
REQ-019 SHALL drive master_data_o and master_src_o from the selected/locked requester; with master_valid_o = 0, master_src_o = rr_ptr and master_data_o = payload of requester rr_ptr.
REQ-020 SHALL assert slave_ready_o[sel] = master_ready_i only for the selected requester; all others 0.
REQ-021 Handshake (master_valid_o & master_ready_i) SHALL set rr_ptr = (sel+1) mod NUM_REQ, increment the outstanding count, and leave/stay in ARB.
REQ-022 master_valid_o & !master_ready_i in ARB SHALL register sel and enter LOCKED.
REQ-023 In LOCKED, SHALL hold master_valid_o = 1 and the registered sel regardless of other requesters, slave_valid_i changes, or the outstanding count, until handshake; then SHALL behave as REQ-021 and return to ARB.
REQ-024 r_done_i with count > 0 SHALL decrement the count; r_done_i with count == 0 SHALL be ignored (no underflow).
REQ-025 Simultaneous handshake and r_done_i SHALL leave the count unchanged.
REQ-026 Count SHALL never exceed MAX_OUTSTANDING; throttle takes effect the cycle after the count reaches MAX_OUTSTANDING, and release the cycle after it drops below.
REQ-027 An r_done_i in the cycle the count is at MAX_OUTSTANDING SHALL allow arbitration in the following cycle.

Reset
REQ-028 While rst_i = 1, SHALL force state = ARB, rr_ptr = 0, count = 0, locked sel = 0; outputs master_valid_o = 0, slave_ready_o = 0, master_src_o = 0, outstanding_o = 0.
REQ-029 Reset asserted in LOCKED SHALL abandon the pending AR; no handshake for it is reported after reset release.

Verification
REQ-030 After reset, requesters 0..3 all valid, master_ready_i = 1 for 4 cycles -> grants 0,1,2,3 in order, outstanding_o = 4.
REQ-031 Requester 2 valid, master_ready_i = 0 for 3 cycles, requester 0 raises valid in cycle 2 -> master_src_o stays 2, master_data_o stable, grant to 2 on cycle 4, then 0.
REQ-032 MAX_OUTSTANDING = 2, continuous requests, no r_done_i -> exactly 2 handshakes, master_valid_o = 0 thereafter; one r_done_i pulse -> exactly one further handshake.
REQ-033 Handshake coincident with r_done_i at count = 1 -> count remains 1; r_done_i at count = 0 -> count remains 0.
REQ-034 rst_i asserted asynchronously mid-cycle while LOCKED -> master_valid_o and slave_ready_o drop immediately, rr_ptr = 0, first grant after release goes to lowest-index valid requester.
